// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable multi-channel clock divider.
// The config-check function is the single definition of a legal (div, high) pair.
package freq_div_pkg;

   localparam int FD_CNT_W    = 24;
   localparam int FD_NUM_CH   = 2;
   localparam int FD_DEF_DIV  = 10000000;
   localparam int FD_DEF_HIGH = 5000000;

   function automatic int ch_idx_w(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

   // A period needs at least two cycles, and the high phase must leave a low phase.
   function automatic logic cfg_ok(input longint unsigned div, input longint unsigned high);
      return (div >= 64'd2) && (high != 64'd0) && (high < div);
   endfunction

endpackage

// File: rtl/freq_div_if.sv
// Configuration request bus of the divider: valid/ready handshake plus a
// registered error pulse for rejected requests.
interface freq_div_if
   import freq_div_pkg::*;
#(
   parameter int CNT_W  = FD_CNT_W,
   parameter int NUM_CH = FD_NUM_CH
);

   localparam int CH_W = ch_idx_w(NUM_CH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic [CNT_W-1:0] cfg_high;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_high,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_high,
      output cfg_ready, cfg_err
   );

endinterface

// File: rtl/freq_div_ch.sv
// One divider channel: active/shadow ratio pair, period counter and registered
// clk_out/tick. Shadow values only take effect at a period boundary or while idle.
module freq_div_ch
   import freq_div_pkg::*;
#(
   parameter int CNT_W    = FD_CNT_W,
   parameter int DEF_DIV  = FD_DEF_DIV,
   parameter int DEF_HIGH = FD_DEF_HIGH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] act_div;
   logic [CNT_W-1:0] act_high;
   logic [CNT_W-1:0] sh_div;
   logic [CNT_W-1:0] sh_high;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] div_next;
   logic [CNT_W-1:0] high_next;
   logic             run;
   logic             wrap;
   logic             activate;

   // run marks that the previous cycle was enabled, so the first enabled cycle starts at cnt=0.
   always_comb begin
      wrap      = run && en && (cnt == act_div - ONE);
      activate  = pending && (!en || wrap);
      div_next  = activate ? sh_div  : act_div;
      high_next = activate ? sh_high : act_high;
      if (!en || !run || wrap) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt + ONE;
      end
   end

   // Outputs are derived from the next-state counter and ratio so they line up with cnt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_div  <= CNT_W'(DEF_DIV);
         act_high <= CNT_W'(DEF_HIGH);
         sh_div   <= '0;
         sh_high  <= '0;
         pending  <= 1'b0;
         cnt      <= '0;
         run      <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
      end else begin
         run     <= en;
         cnt     <= cnt_next;
         clk_out <= en && (cnt_next < high_next);
         tick    <= en && (cnt_next == div_next - ONE);
         if (activate) begin
            act_div  <= sh_div;
            act_high <= sh_high;
            pending  <= 1'b0;
         end
         if (cfg_wr) begin
            sh_div  <= cfg_div;
            sh_high <= cfg_high;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/freq_div_prog.sv
// Programmable multi-channel clock divider top: decodes configuration requests,
// routes legal ones to the addressed channel and flags rejected ones on cfg_err.
module freq_div_prog
   import freq_div_pkg::*;
#(
   parameter int CNT_W    = FD_CNT_W,
   parameter int NUM_CH   = FD_NUM_CH,
   parameter int DEF_DIV  = FD_DEF_DIV,
   parameter int DEF_HIGH = FD_DEF_HIGH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   freq_div_if.slave         cfg,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam int CH_W  = ch_idx_w(NUM_CH);
   localparam int PAD_N = 1 << CH_W;

   if ((DEF_DIV < 2) || (DEF_HIGH == 0) || (DEF_HIGH >= DEF_DIV) ||
       (longint'(DEF_DIV) >= (longint'(1) << CNT_W)) || (NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_params
      $error("freq_div_prog: illegal default ratio or channel count");
   end

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] cfg_wr;
   logic [PAD_N-1:0]  pend_pad;
   logic              in_range;
   logic              ready;
   logic              accept;
   logic              good;

   // Out-of-range channels report ready so the request is taken and then rejected.
   always_comb begin
      pend_pad = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pend_pad[i] = pending[i];
      end
      in_range = (int'(cfg.cfg_ch) < NUM_CH);
      ready    = !(in_range && pend_pad[cfg.cfg_ch]);
      accept   = cfg.cfg_valid && ready;
      good     = accept && in_range && cfg_ok(64'(cfg.cfg_div), 64'(cfg.cfg_high));
      cfg_wr   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_wr[i] = good && (int'(cfg.cfg_ch) == i);
      end
   end

   assign cfg.cfg_ready = ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg.cfg_err <= 1'b0;
      end else begin
         cfg.cfg_err <= accept && !good;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      freq_div_ch #(
         .CNT_W    (CNT_W),
         .DEF_DIV  (DEF_DIV),
         .DEF_HIGH (DEF_HIGH)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .en       (en[g]),
         .cfg_wr   (cfg_wr[g]),
         .cfg_div  (cfg.cfg_div),
         .cfg_high (cfg.cfg_high),
         .pending  (pending[g]),
         .clk_out  (clk_out[g]),
         .tick     (tick[g])
      );
   end

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed bench for freq_div_prog with an 8-bit counter and a default 10/5 ratio;
// a second three-channel instance covers the out-of-range channel index.
module tb_freq_div_prog;

   localparam int CNT_W    = 8;
   localparam int DEF_DIV  = 10;
   localparam int DEF_HIGH = 5;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] en    = 2'b00;
   logic [1:0] clk_out;
   logic [1:0] tick;
   logic [2:0] en3   = 3'b111;
   logic [2:0] clk_out3;
   logic [2:0] tick3;

   int check_cnt = 0;
   int pass_cnt  = 0;

   freq_div_if #(.CNT_W(CNT_W), .NUM_CH(2)) cfg_bus ();
   freq_div_if #(.CNT_W(CNT_W), .NUM_CH(3)) cfg_bus3 ();

   freq_div_prog #(
      .CNT_W(CNT_W), .NUM_CH(2), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)
   ) u_dut (
      .clk(clk), .reset(reset), .en(en), .cfg(cfg_bus.slave),
      .clk_out(clk_out), .tick(tick)
   );

   freq_div_prog #(
      .CNT_W(CNT_W), .NUM_CH(3), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)
   ) u_dut3 (
      .clk(clk), .reset(reset), .en(en3), .cfg(cfg_bus3.slave),
      .clk_out(clk_out3), .tick(tick3)
   );

   always #5 clk = ~clk;

   task automatic cfg_idle();
      cfg_bus.cfg_valid  = 1'b0;
      cfg_bus.cfg_ch     = '0;
      cfg_bus.cfg_div    = '0;
      cfg_bus.cfg_high   = '0;
      cfg_bus3.cfg_valid = 1'b0;
      cfg_bus3.cfg_ch    = '0;
      cfg_bus3.cfg_div   = '0;
      cfg_bus3.cfg_high  = '0;
   endtask

   // Leaves the bench on the negedge of the first counting cycle (cnt=0).
   task automatic restart_dut(input logic [1:0] en_val);
      @(negedge clk);
      reset = 1'b1;
      en    = en_val;
      cfg_idle();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [1:0] exp_clk, exp_tick;
      cfg_idle();
      en = 2'b00;
      #2 reset = 1'b1;
      #1;
      check_cnt++;
      if (clk_out !== 2'b00) $display("[TB] FAIL reset_clk_out: got %b expected 00", clk_out); else pass_cnt++;
      check_cnt++;
      if (tick !== 2'b00) $display("[TB] FAIL reset_tick: got %b expected 00", tick); else pass_cnt++;
      check_cnt++;
      if (cfg_bus.cfg_err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", cfg_bus.cfg_err); else pass_cnt++;
      check_cnt++;
      if (cfg_bus.cfg_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", cfg_bus.cfg_ready); else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      en    = 2'b11;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         exp_clk  = ((k % 10) < 5)  ? 2'b11 : 2'b00;
         exp_tick = ((k % 10) == 9) ? 2'b11 : 2'b00;
         check_cnt++;
         if (clk_out !== exp_clk) $display("[TB] FAIL default_clk k=%0d: got %b expected %b", k, clk_out, exp_clk); else pass_cnt++;
         check_cnt++;
         if (tick !== exp_tick) $display("[TB] FAIL default_tick k=%0d: got %b expected %b", k, tick, exp_tick); else pass_cnt++;
      end
   endtask

   task automatic test_reconfig();
      logic [1:0] exp_clk, exp_tick;
      restart_dut(2'b11);
      repeat (3) @(negedge clk);
      cfg_bus.cfg_ch    = 1'b0;
      cfg_bus.cfg_div   = 8'd4;
      cfg_bus.cfg_high  = 8'd1;
      cfg_bus.cfg_valid = 1'b1;
      #1;
      check_cnt++;
      if (cfg_bus.cfg_ready !== 1'b1) $display("[TB] FAIL reconfig_ready_pre: got %b expected 1", cfg_bus.cfg_ready); else pass_cnt++;
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      check_cnt++;
      if (cfg_bus.cfg_err !== 1'b0) $display("[TB] FAIL reconfig_err: got %b expected 0", cfg_bus.cfg_err); else pass_cnt++;
      for (int c = 4; c < 10; c++) begin
         if (c > 4) @(negedge clk);
         check_cnt++;
         if (cfg_bus.cfg_ready !== 1'b0) $display("[TB] FAIL reconfig_ready_pend c=%0d: got %b expected 0", c, cfg_bus.cfg_ready); else pass_cnt++;
         check_cnt++;
         if (clk_out[0] !== (c < 5)) $display("[TB] FAIL reconfig_old_clk c=%0d: got %b expected %b", c, clk_out[0], (c < 5)); else pass_cnt++;
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         exp_clk[1]  = ((k % 10) < 5);
         exp_clk[0]  = ((k % 4) < 1);
         exp_tick[1] = ((k % 10) == 9);
         exp_tick[0] = ((k % 4) == 3);
         check_cnt++;
         if (clk_out !== exp_clk) $display("[TB] FAIL reconfig_clk k=%0d: got %b expected %b", k, clk_out, exp_clk); else pass_cnt++;
         check_cnt++;
         if (tick !== exp_tick) $display("[TB] FAIL reconfig_tick k=%0d: got %b expected %b", k, tick, exp_tick); else pass_cnt++;
         if (k == 0) begin
            check_cnt++;
            if (cfg_bus.cfg_ready !== 1'b1) $display("[TB] FAIL reconfig_ready_post: got %b expected 1", cfg_bus.cfg_ready); else pass_cnt++;
         end
      end
   endtask

   task automatic test_reject();
      int rej_div  [3] = '{1, 6, 6};
      int rej_high [3] = '{1, 6, 0};
      logic [1:0] exp_clk, exp_tick;
      restart_dut(2'b11);
      for (int r = 0; r < 3; r++) begin
         cfg_bus.cfg_ch    = 1'b0;
         cfg_bus.cfg_div   = 8'(rej_div[r]);
         cfg_bus.cfg_high  = 8'(rej_high[r]);
         cfg_bus.cfg_valid = 1'b1;
         #1;
         check_cnt++;
         if (cfg_bus.cfg_ready !== 1'b1) $display("[TB] FAIL reject_ready r=%0d: got %b expected 1", r, cfg_bus.cfg_ready); else pass_cnt++;
         @(negedge clk);
         cfg_bus.cfg_valid = 1'b0;
         check_cnt++;
         if (cfg_bus.cfg_err !== 1'b1) $display("[TB] FAIL reject_err r=%0d: got %b expected 1", r, cfg_bus.cfg_err); else pass_cnt++;
         @(negedge clk);
         check_cnt++;
         if (cfg_bus.cfg_err !== 1'b0) $display("[TB] FAIL reject_err_clear r=%0d: got %b expected 0", r, cfg_bus.cfg_err); else pass_cnt++;
      end
      for (int k = 7; k < 17; k++) begin
         @(negedge clk);
         exp_clk  = ((k % 10) < 5)  ? 2'b11 : 2'b00;
         exp_tick = ((k % 10) == 9) ? 2'b11 : 2'b00;
         check_cnt++;
         if (clk_out !== exp_clk) $display("[TB] FAIL reject_clk k=%0d: got %b expected %b", k, clk_out, exp_clk); else pass_cnt++;
         check_cnt++;
         if (tick !== exp_tick) $display("[TB] FAIL reject_tick k=%0d: got %b expected %b", k, tick, exp_tick); else pass_cnt++;
      end
   endtask

   task automatic test_out_of_range();
      restart_dut(2'b11);
      check_cnt++;
      if (clk_out3 !== 3'b111) $display("[TB] FAIL range_clk3: got %b expected 111", clk_out3); else pass_cnt++;
      check_cnt++;
      if (tick3 !== 3'b000) $display("[TB] FAIL range_tick3: got %b expected 000", tick3); else pass_cnt++;
      cfg_bus3.cfg_ch    = 2'd3;
      cfg_bus3.cfg_div   = 8'd4;
      cfg_bus3.cfg_high  = 8'd1;
      cfg_bus3.cfg_valid = 1'b1;
      #1;
      check_cnt++;
      if (cfg_bus3.cfg_ready !== 1'b1) $display("[TB] FAIL range_ready: got %b expected 1", cfg_bus3.cfg_ready); else pass_cnt++;
      @(negedge clk);
      check_cnt++;
      if (cfg_bus3.cfg_err !== 1'b1) $display("[TB] FAIL range_err_ch3: got %b expected 1", cfg_bus3.cfg_err); else pass_cnt++;
      cfg_bus3.cfg_ch = 2'd2;
      @(negedge clk);
      cfg_bus3.cfg_valid = 1'b0;
      check_cnt++;
      if (cfg_bus3.cfg_err !== 1'b0) $display("[TB] FAIL range_err_ch2: got %b expected 0", cfg_bus3.cfg_err); else pass_cnt++;
      check_cnt++;
      if (cfg_bus3.cfg_ready !== 1'b0) $display("[TB] FAIL range_ready_ch2: got %b expected 0", cfg_bus3.cfg_ready); else pass_cnt++;
   endtask

   task automatic test_wrap_accept();
      restart_dut(2'b11);
      repeat (9) @(negedge clk);
      cfg_bus.cfg_ch    = 1'b0;
      cfg_bus.cfg_div   = 8'd4;
      cfg_bus.cfg_high  = 8'd2;
      cfg_bus.cfg_valid = 1'b1;
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      check_cnt++;
      if (cfg_bus.cfg_ready !== 1'b0) $display("[TB] FAIL wrap_ready_pend: got %b expected 0", cfg_bus.cfg_ready); else pass_cnt++;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         check_cnt++;
         if (clk_out[0] !== (k < 5)) $display("[TB] FAIL wrap_old_clk k=%0d: got %b expected %b", k, clk_out[0], (k < 5)); else pass_cnt++;
         check_cnt++;
         if (tick[0] !== (k == 9)) $display("[TB] FAIL wrap_old_tick k=%0d: got %b expected %b", k, tick[0], (k == 9)); else pass_cnt++;
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check_cnt++;
         if (clk_out[0] !== ((k % 4) < 2)) $display("[TB] FAIL wrap_new_clk k=%0d: got %b expected %b", k, clk_out[0], ((k % 4) < 2)); else pass_cnt++;
         check_cnt++;
         if (tick[0] !== ((k % 4) == 3)) $display("[TB] FAIL wrap_new_tick k=%0d: got %b expected %b", k, tick[0], ((k % 4) == 3)); else pass_cnt++;
      end
   endtask

   task automatic test_disable();
      int c0;
      restart_dut(2'b11);
      repeat (2) @(negedge clk);
      c0 = 2;
      en = 2'b01;
      @(negedge clk);
      c0 = 3;
      check_cnt++;
      if (clk_out !== 2'b01) $display("[TB] FAIL dis_clk_off: got %b expected 01", clk_out); else pass_cnt++;
      check_cnt++;
      if (tick[1] !== 1'b0) $display("[TB] FAIL dis_tick_off: got %b expected 0", tick[1]); else pass_cnt++;
      cfg_bus.cfg_ch    = 1'b1;
      cfg_bus.cfg_div   = 8'd3;
      cfg_bus.cfg_high  = 8'd2;
      cfg_bus.cfg_valid = 1'b1;
      @(negedge clk);
      c0 = 4;
      cfg_bus.cfg_valid = 1'b0;
      check_cnt++;
      if (cfg_bus.cfg_ready !== 1'b0) $display("[TB] FAIL dis_ready_pend: got %b expected 0", cfg_bus.cfg_ready); else pass_cnt++;
      check_cnt++;
      if (clk_out[1] !== 1'b0) $display("[TB] FAIL dis_clk_idle: got %b expected 0", clk_out[1]); else pass_cnt++;
      @(negedge clk);
      c0 = 5;
      check_cnt++;
      if (cfg_bus.cfg_ready !== 1'b1) $display("[TB] FAIL dis_ready_applied: got %b expected 1", cfg_bus.cfg_ready); else pass_cnt++;
      check_cnt++;
      if (clk_out !== 2'b00) $display("[TB] FAIL dis_clk_both: got %b expected 00", clk_out); else pass_cnt++;
      en = 2'b11;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         c0 = (c0 + 1) % 10;
         check_cnt++;
         if (clk_out[1] !== ((k % 3) < 2)) $display("[TB] FAIL dis_ch1_clk k=%0d: got %b expected %b", k, clk_out[1], ((k % 3) < 2)); else pass_cnt++;
         check_cnt++;
         if (tick[1] !== ((k % 3) == 2)) $display("[TB] FAIL dis_ch1_tick k=%0d: got %b expected %b", k, tick[1], ((k % 3) == 2)); else pass_cnt++;
         check_cnt++;
         if (clk_out[0] !== (c0 < 5)) $display("[TB] FAIL dis_ch0_clk c=%0d: got %b expected %b", c0, clk_out[0], (c0 < 5)); else pass_cnt++;
         check_cnt++;
         if (tick[0] !== (c0 == 9)) $display("[TB] FAIL dis_ch0_tick c=%0d: got %b expected %b", c0, tick[0], (c0 == 9)); else pass_cnt++;
      end
   endtask

   task automatic test_reset_pending();
      logic [1:0] exp_clk, exp_tick;
      restart_dut(2'b11);
      cfg_bus.cfg_ch    = 1'b0;
      cfg_bus.cfg_div   = 8'd4;
      cfg_bus.cfg_high  = 8'd1;
      cfg_bus.cfg_valid = 1'b1;
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      check_cnt++;
      if (cfg_bus.cfg_ready !== 1'b0) $display("[TB] FAIL rstp_ready_pend: got %b expected 0", cfg_bus.cfg_ready); else pass_cnt++;
      check_cnt++;
      if (clk_out !== 2'b11) $display("[TB] FAIL rstp_clk_pre: got %b expected 11", clk_out); else pass_cnt++;
      #2 reset = 1'b1;
      #1;
      check_cnt++;
      if (clk_out !== 2'b00) $display("[TB] FAIL rstp_clk_async: got %b expected 00", clk_out); else pass_cnt++;
      check_cnt++;
      if (tick !== 2'b00) $display("[TB] FAIL rstp_tick_async: got %b expected 00", tick); else pass_cnt++;
      check_cnt++;
      if (cfg_bus.cfg_ready !== 1'b1) $display("[TB] FAIL rstp_ready_async: got %b expected 1", cfg_bus.cfg_ready); else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         exp_clk  = ((k % 10) < 5)  ? 2'b11 : 2'b00;
         exp_tick = ((k % 10) == 9) ? 2'b11 : 2'b00;
         check_cnt++;
         if (clk_out !== exp_clk) $display("[TB] FAIL rstp_clk k=%0d: got %b expected %b", k, clk_out, exp_clk); else pass_cnt++;
         check_cnt++;
         if (tick !== exp_tick) $display("[TB] FAIL rstp_tick k=%0d: got %b expected %b", k, tick, exp_tick); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_reconfig();
      test_reject();
      test_out_of_range();
      test_wrap_accept();
      test_disable();
      test_reset_pending();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
